// File: rtl/rv32_ex_muldiv.sv
// rv32_ex_muldiv: iterative RV32M multiply/divide execute unit, stalls the front end while it runs
module rv32_ex_muldiv #(
  parameter int XLEN = 32,
  parameter int STEP_BITS = 1,
  parameter int FAST_SPECIAL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [31:0]     pc_in,
  input  logic [31:0]     iw_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      wb_reg_in,
  input  logic            wb_enable_in,
  input  logic            flush,
  output logic            stall_out,
  output logic            busy_out,
  output logic [4:0]      busy_reg_out,
  output logic            out_valid,
  output logic [31:0]     pc_out,
  output logic [31:0]     iw_out,
  output logic [XLEN-1:0] alu_out,
  output logic [4:0]      wb_reg_out,
  output logic            wb_enable_out
);
  localparam int N = XLEN / STEP_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step, prod;
  logic [XLEN-1:0] opa_q, res_o_q, m1, m2, spec_res, res, quot, rem, dr, dq;
  logic [XLEN+STEP_BITS-1:0] mul_sum;
  logic [XLEN:0] dt;
  logic [31:0] pc_q, iw_q, pc_o_q, iw_o_q;
  logic [4:0] rd_q, rd_o_q;
  logic [2:0] op_q, f3;
  logic wbe_q, wbe_o_q, neg_q, rneg_q;
  logic is_m, is_div, s1, s2, special, accept, enter_done;
  assign f3 = iw_in[14:12];
  assign is_m = iw_in[6:0] == 7'b0110011 && iw_in[31:25] == 7'b0000001;
  assign is_div = f3[2];
  assign s1 = rs1_data_in[XLEN-1] & (is_div ? ~f3[0] : f3[0] ^ f3[1]);
  assign s2 = rs2_data_in[XLEN-1] & (is_div ? ~f3[0] : f3[1:0] == 2'b01);
  assign m1 = s1 ? -rs1_data_in : rs1_data_in;
  assign m2 = s2 ? -rs2_data_in : rs2_data_in;
  assign special = FAST_SPECIAL != 0 && is_div &&
                   (rs2_data_in == '0 || (!f3[0] && rs1_data_in == MIN && rs2_data_in == '1));
  assign spec_res = rs2_data_in == '0 ? (f3[1] ? rs1_data_in : '1) : (f3[1] ? '0 : rs1_data_in);
  assign accept = state_q == IDLE && in_valid && is_m && !flush;
  // One iteration: multiply adds opa*digit into the high half and shifts right;
  // divide shifts the dividend out of the low half into the partial remainder.
  always_comb begin
    mul_sum = {{STEP_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} +
              {{STEP_BITS{1'b0}}, opa_q} * (XLEN+STEP_BITS)'(acc_q[STEP_BITS-1:0]);
    dr = acc_q[2*XLEN-1:XLEN];
    dq = acc_q[XLEN-1:0];
    dt = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      dt = {dr, dq[XLEN-1]};
      dr = dt >= {1'b0, opa_q} ? XLEN'(dt - {1'b0, opa_q}) : dt[XLEN-1:0];
      dq = {dq[XLEN-2:0], dt >= {1'b0, opa_q}};
    end
    acc_step = op_q[2] ? {dr, dq} : {mul_sum, acc_q[XLEN-1:STEP_BITS]};
  end
  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
  assign res = op_q[2] ? (op_q[1] ? rem : quot)
                       : (op_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (special ? DONE : RUN) : IDLE;
      RUN:     state_d = flush ? IDLE : (cnt_q == '0 ? DONE : RUN);
      default: state_d = IDLE;
    endcase
  end
  assign enter_done = state_d == DONE && state_q != DONE;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      opa_q <= '0;
      op_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      pc_q <= '0;
      iw_q <= '0;
      rd_q <= '0;
      wbe_q <= 1'b0;
      pc_o_q <= '0;
      iw_o_q <= '0;
      rd_o_q <= '0;
      wbe_o_q <= 1'b0;
      res_o_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q <= pc_in;
        iw_q <= iw_in;
        rd_q <= wb_reg_in;
        wbe_q <= wb_enable_in;
        op_q <= f3;
        opa_q <= is_div ? m2 : m1;
        acc_q <= {{XLEN{1'b0}}, is_div ? m1 : m2};
        // A zero divisor yields an all-ones quotient regardless of operand signs
        neg_q <= (s1 ^ s2) & (!is_div || rs2_data_in != '0);
        rneg_q <= s1;
        cnt_q <= CW'(N);
      end else if (state_q == RUN && cnt_q != '0) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q - CW'(1);
      end
      if (enter_done) begin
        pc_o_q <= state_q == IDLE ? pc_in : pc_q;
        iw_o_q <= state_q == IDLE ? iw_in : iw_q;
        rd_o_q <= state_q == IDLE ? wb_reg_in : rd_q;
        wbe_o_q <= state_q == IDLE ? wb_enable_in : wbe_q;
        res_o_q <= state_q == IDLE ? spec_res : res;
      end
    end
  end
  assign stall_out = (state_q == IDLE && in_valid && is_m) || state_q == RUN;
  assign busy_out = state_q != IDLE;
  assign busy_reg_out = busy_out ? rd_q : '0;
  assign out_valid = state_q == DONE;
  assign pc_out = pc_o_q;
  assign iw_out = iw_o_q;
  assign alu_out = res_o_q;
  assign wb_reg_out = rd_o_q;
  assign wb_enable_out = wbe_o_q & out_valid;
endmodule

// File: tb/tb_rv32_ex_muldiv.sv
// tb_rv32_ex_muldiv: three configurations of the M unit checked every cycle against a latency/result model
module tb_rv32_ex_muldiv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic wb_enable_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] iw_in = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0] wb_reg_in = '0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;

  task automatic chk(int c, string n, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL cfg%0d %s: got %h expected %h at %0t", c, n, act, exp, $time);
    end
  endtask

  function automatic bit is_m(logic [31:0] iw);
    return iw[6:0] == 7'h33 && iw[31:25] == 7'h01;
  endfunction

  function automatic bit is_special(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] ref_res(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint ub = longint'({32'b0, b});
    logic [63:0] uu = {32'b0, a} * {32'b0, b};
    longint p;
    case (f)
      3'd0: return 32'(sa * sb);
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: return uu[63:32];
      3'd4: return b == 0 ? 32'hFFFFFFFF : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
      3'd6: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int SB = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    localparam int FS = (g == 1) ? 0 : 1;
    localparam int NN = 32 / SB;
    logic stall, busy, ov, wbe;
    logic [4:0] brd, rdo;
    logic [31:0] pco, iwo, alu;
    rv32_ex_muldiv #(.XLEN(32), .STEP_BITS(SB), .FAST_SPECIAL(FS)) u (
      .clk(clk), .reset(reset), .in_valid(in_valid), .pc_in(pc_in), .iw_in(iw_in),
      .rs1_data_in(rs1), .rs2_data_in(rs2), .wb_reg_in(wb_reg_in), .wb_enable_in(wb_enable_in),
      .flush(flush), .stall_out(stall), .busy_out(busy), .busy_reg_out(brd), .out_valid(ov),
      .pc_out(pco), .iw_out(iwo), .alu_out(alu), .wb_reg_out(rdo), .wb_enable_out(wbe)
    );
    // Model: cd counts edges left until the result appears; done marks the result cycle.
    int cd;
    bit done, e_wbe, p_wbe;
    logic [31:0] e_pc, e_iw, e_alu, p_pc, p_iw, p_res;
    logic [4:0] e_rd, p_rd;
    always @(posedge clk or negedge reset) begin
      if (!reset) begin
        cd <= 0; done <= 0; e_pc <= 0; e_iw <= 0; e_alu <= 0; e_rd <= 0; e_wbe <= 0; p_rd <= 0;
      end else if (done) begin
        done <= 0;
      end else if (cd > 0) begin
        if (flush) cd <= 0;
        else begin
          cd <= cd - 1;
          if (cd == 1) begin
            done <= 1; e_pc <= p_pc; e_iw <= p_iw; e_alu <= p_res; e_rd <= p_rd; e_wbe <= p_wbe;
          end
        end
      end else if (in_valid && is_m(iw_in) && !flush) begin
        p_pc <= pc_in; p_iw <= iw_in; p_rd <= wb_reg_in; p_wbe <= wb_enable_in;
        p_res <= ref_res(iw_in[14:12], rs1, rs2);
        if (FS != 0 && is_special(iw_in[14:12], rs1, rs2)) begin
          done <= 1; e_pc <= pc_in; e_iw <= iw_in; e_rd <= wb_reg_in; e_wbe <= wb_enable_in;
          e_alu <= ref_res(iw_in[14:12], rs1, rs2);
        end else cd <= NN + 1;
      end
    end
    always @(negedge clk) begin
      chk(g, "stall_out", 32'(stall), 32'(cd > 0 || (!done && in_valid && is_m(iw_in))));
      chk(g, "busy_out", 32'(busy), 32'(cd > 0 || done));
      chk(g, "busy_reg_out", 32'(brd), (cd > 0 || done) ? 32'(p_rd) : 32'd0);
      chk(g, "out_valid", 32'(ov), 32'(done));
      chk(g, "wb_enable_out", 32'(wbe), 32'(done && e_wbe));
      chk(g, "pc_out", pco, e_pc);
      chk(g, "iw_out", iwo, e_iw);
      chk(g, "alu_out", alu, e_alu);
      chk(g, "wb_reg_out", 32'(rdo), 32'(e_rd));
    end
  end

  typedef struct {
    logic [2:0] f;
    logic [31:0] a, b, r;
  } vec_t;
  vec_t vecs[16] = '{
    '{3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB},
    '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
    '{3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF},
    '{3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF},
    '{3'd6, 32'h1234, 32'd0, 32'h1234},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000},
    '{3'd4, 32'h80000000, 32'd0, 32'hFFFFFFFF},
    '{3'd6, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9},
    '{3'd5, 32'd100, 32'd7, 32'd14},
    '{3'd7, 32'd100, 32'd7, 32'd2}
  };
  logic [4:0] rd_n = 5'd1;

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] m_iw(logic [2:0] f, logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f, rd, 7'b0110011};
  endfunction

  task automatic issue(logic [31:0] iw, logic [31:0] a, logic [31:0] b, bit fl);
    pc_in = pc_in + 32'd4;
    iw_in = iw;
    rs1 = a;
    rs2 = b;
    wb_reg_in = iw[11:7];
    wb_enable_in = iw[7] | iw[8];
    in_valid = 1'b1;
    flush = fl;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    rd_n = rd_n + 5'd3;
  endtask

  task automatic run_op(vec_t v);
    chk(-1, "model", ref_res(v.f, v.a, v.b), v.r);
    issue(m_iw(v.f, rd_n), v.a, v.b, 1'b0);
    repeat (36) step();
    chk(0, "result", cfg[0].alu, v.r);
    chk(1, "result", cfg[1].alu, v.r);
    chk(2, "result", cfg[2].alu, v.r);
  endtask

  initial begin
    step();
    step();
    chk(0, "reset alu_out", cfg[0].alu, 32'd0);
    chk(0, "reset busy_out", 32'(cfg[0].busy), 32'd0);
    reset = 1'b1;
    step();
    foreach (vecs[i]) run_op(vecs[i]);
    issue(m_iw(3'd5, rd_n), 32'd100, 32'd7, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk(0, "flushed stall_out", 32'(cfg[0].stall), 32'd0);
    repeat (36) step();
    chk(0, "flush keeps result", cfg[0].alu, 32'd2);
    chk(1, "flush keeps result", cfg[1].alu, 32'd2);
    chk(2, "flush in DONE ignored", cfg[2].alu, 32'd14);
    issue({7'b0, 5'd2, 5'd1, 3'b000, 5'd9, 7'b0110011}, 32'd5, 32'd6, 1'b0);
    issue(m_iw(3'd0, rd_n), 32'd5, 32'd6, 1'b1);
    repeat (36) step();
    chk(0, "idle flush blocks accept", cfg[0].alu, 32'd2);
    issue(m_iw(3'd0, rd_n), 32'h12345, 32'h10, 1'b0);
    repeat (5) step();
    #2 reset = 1'b0;
    #1;
    chk(0, "async reset alu_out", cfg[0].alu, 32'd0);
    chk(0, "async reset pc_out", cfg[0].pco, 32'd0);
    chk(0, "async reset busy_out", 32'(cfg[0].busy), 32'd0);
    chk(0, "async reset stall_out", 32'(cfg[0].stall), 32'd0);
    chk(1, "async reset busy_reg_out", 32'(cfg[1].brd), 32'd0);
    step();
    reset = 1'b1;
    step();
    run_op('{3'd0, 32'd3, 32'd5, 32'd15});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
